sw_debounce: RTL

- Input conditioning stage directly upstream of the Avalon PIO slave.
- Synchronises the raw slide-switch inputs into the clk domain and debounces each bit independently.
- Drives the PIO's SW port with a stable vector.
- Emits per-bit one-cycle change pulses for later edge-capture or interrupt logic.

---
 rtl/sw_debounce.sv | 77 +++++++
 1 files changed

// File: rtl/sw_debounce.sv
// Slide-switch conditioner: two-flop synchroniser, shared sample-tick prescaler and
// independent per-bit stability counters, with registered per-bit change pulses.
module sw_debounce #(
   parameter int unsigned WIDTH        = 4,
   parameter int unsigned TICK_DIV     = 50000,
   parameter int unsigned STABLE_TICKS = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] sw_in,
   output logic [WIDTH-1:0] sw_out,
   output logic [WIDTH-1:0] changed,
   output logic             any_changed
);

   localparam int unsigned PW = $clog2(TICK_DIV);
   localparam int unsigned CW = $clog2(STABLE_TICKS + 1);
   localparam logic [PW-1:0] PreLast = PW'(TICK_DIV - 1);
   localparam logic [CW-1:0] CntLast = CW'(STABLE_TICKS - 1);

   logic [WIDTH-1:0]         sync1_q;
   logic [WIDTH-1:0]         s_q;
   logic [WIDTH-1:0]         sw_out_q, sw_out_d;
   logic [WIDTH-1:0]         changed_q, changed_d;
   logic                     any_q;
   logic [PW-1:0]            pre_q, pre_d;
   logic                     tick;
   logic [WIDTH-1:0][CW-1:0] cnt_q, cnt_d;

   assign tick  = (pre_q == PreLast);
   assign pre_d = tick ? '0 : pre_q + PW'(1);

   always_comb begin
      sw_out_d  = sw_out_q;
      changed_d = '0;
      cnt_d     = cnt_q;
      for (int i = 0; i < WIDTH; i++) begin
         // Any cycle where the input agrees with the output discards accumulated credit.
         if (s_q[i] == sw_out_q[i]) begin
            cnt_d[i] = '0;
         end else if (tick) begin
            if (cnt_q[i] == CntLast) begin
               sw_out_d[i]  = s_q[i];
               cnt_d[i]     = '0;
               changed_d[i] = 1'b1;
            end else begin
               cnt_d[i] = cnt_q[i] + CW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q   <= '0;
         s_q       <= '0;
         sw_out_q  <= '0;
         changed_q <= '0;
         any_q     <= 1'b0;
         pre_q     <= '0;
         cnt_q     <= '0;
      end else begin
         sync1_q   <= sw_in;
         s_q       <= sync1_q;
         sw_out_q  <= sw_out_d;
         changed_q <= changed_d;
         any_q     <= |changed_d;
         pre_q     <= pre_d;
         cnt_q     <= cnt_d;
      end
   end

   assign sw_out      = sw_out_q;
   assign changed     = changed_q;
   assign any_changed = any_q;

endmodule
